// File: rtl/fft_pkg.sv
// Shared fixed-point FFT definitions for the forward and inverse butterfly datapaths.
package fft_pkg;

  localparam int unsigned FFT_W    = 16;
  localparam int unsigned FRAC     = FFT_W - 1;
  localparam int unsigned NARROW_W = 64;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic ovf;
    logic clamp;
    logic neg;
  } narrow_t;

  // Range check of a sign-extended wide result against signed w bits; the caller
  // selects the clamp value or the low w bits from the returned decision.
  function automatic narrow_t sat_narrow(input logic signed [NARROW_W-1:0] v,
                                         input int unsigned               w,
                                         input logic                      sat_en);
    logic signed [NARROW_W-1:0] hi;
    narrow_t                    r;
    hi      = $signed((NARROW_W'(1) << (w - 1)) - NARROW_W'(1));
    r.ovf   = (v > hi) || (v < ~hi);
    r.clamp = sat_en && r.ovf;
    r.neg   = v[NARROW_W-1];
    return r;
  endfunction

endpackage

// File: rtl/cmul_conj_pipe.sv
// Two-stage conjugate complex multiply (d * conj(w)) with Q-format shift and narrowing.
module cmul_conj_pipe
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SCALE  = 1,
  parameter bit          SAT_EN = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld2_i,
  input  logic                    ld3_i,
  input  logic signed [WIDTH:0]   d_re_i,
  input  logic signed [WIDTH:0]   d_im_i,
  input  logic signed [WIDTH-1:0] w_re_i,
  input  logic signed [WIDTH-1:0] w_im_i,
  output logic signed [WIDTH-1:0] y_re_o,
  output logic signed [WIDTH-1:0] y_im_o,
  output logic                    y_ovf_o
);

  localparam int unsigned PW    = 2 * WIDTH + 1;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned SHIFT = WIDTH - 1 + SCALE;
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [SW-1:0]    y_re_w, y_im_w;
  logic signed [WIDTH-1:0] y_re_d, y_im_d;
  narrow_t                 n_re, n_im;

  always_ff @(posedge clk or negedge rst_n) begin : s2_reg
    if (!rst_n) begin
      p_rr_q <= '0;
      p_ii_q <= '0;
      p_ir_q <= '0;
      p_ri_q <= '0;
    end else if (ld2_i) begin
      p_rr_q <= PW'(d_re_i) * PW'(w_re_i);
      p_ii_q <= PW'(d_im_i) * PW'(w_im_i);
      p_ir_q <= PW'(d_im_i) * PW'(w_re_i);
      p_ri_q <= PW'(d_re_i) * PW'(w_im_i);
    end
  end

  // conj(w) flips the sign of the cross terms relative to a plain multiply
  always_comb begin
    y_re_w = SW'(p_rr_q) + SW'(p_ii_q);
    y_im_w = SW'(p_ir_q) - SW'(p_ri_q);
    n_re   = sat_narrow(NARROW_W'(y_re_w >>> SHIFT), WIDTH, SAT_EN);
    n_im   = sat_narrow(NARROW_W'(y_im_w >>> SHIFT), WIDTH, SAT_EN);
    y_re_d = n_re.clamp ? (n_re.neg ? Q_MIN : Q_MAX) : WIDTH'(y_re_w >>> SHIFT);
    y_im_d = n_im.clamp ? (n_im.neg ? Q_MIN : Q_MAX) : WIDTH'(y_im_w >>> SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin : s3_reg
    if (!rst_n) begin
      y_re_o  <= '0;
      y_im_o  <= '0;
      y_ovf_o <= 1'b0;
    end else if (ld3_i) begin
      y_re_o  <= y_re_d;
      y_im_o  <= y_im_d;
      y_ovf_o <= n_re.ovf | n_im.ovf;
    end
  end

endmodule

// File: rtl/ibutterfly_dif_pipe.sv
// Pipelined radix-2 DIF inverse butterfly, 3 stages with global stall.
// Define IBFLY_SAT_EN to clamp overflowing outputs instead of wrapping.
module ibutterfly_dif_pipe
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SCALE = 1,
  parameter int unsigned TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  input  logic signed [WIDTH-1:0] w_re,
  input  logic signed [WIDTH-1:0] w_im,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] X_re,
  output logic signed [WIDTH-1:0] X_im,
  output logic signed [WIDTH-1:0] Y_re,
  output logic signed [WIDTH-1:0] Y_im,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    ovf,
  input  logic                    ovf_clr
);

`ifdef IBFLY_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam int unsigned    EW    = WIDTH + 1;
  localparam logic [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic                    en_c, xfer_c;
  logic                    v1_q, v2_q;
  logic signed [EW-1:0]    s_re_q, s_im_q, d_re_q, d_im_q, s2_re_q, s2_im_q;
  logic signed [WIDTH-1:0] w_re_q, w_im_q, x_re_d, x_im_d;
  logic [TAG_W-1:0]        tag1_q, tag2_q;
  logic                    x_ovf_q, y_ovf;
  narrow_t                 n_xre, n_xim;

  assign en_c     = !out_valid | out_ready;
  assign in_ready = en_c;
  assign xfer_c   = out_valid & out_ready;

  // S1: full-precision sum and difference, twiddle captured alongside
  always_ff @(posedge clk or negedge rst_n) begin : s1_reg
    if (!rst_n) begin
      v1_q   <= 1'b0;
      s_re_q <= '0;
      s_im_q <= '0;
      d_re_q <= '0;
      d_im_q <= '0;
      w_re_q <= '0;
      w_im_q <= '0;
      tag1_q <= '0;
    end else if (en_c) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s_re_q <= EW'(a_re) + EW'(b_re);
        s_im_q <= EW'(a_im) + EW'(b_im);
        d_re_q <= EW'(a_re) - EW'(b_re);
        d_im_q <= EW'(a_im) - EW'(b_im);
        w_re_q <= w_re;
        w_im_q <= w_im;
        tag1_q <= in_tag;
      end
    end
  end

  // S2: sum and tag wait beside the products
  always_ff @(posedge clk or negedge rst_n) begin : s2_reg
    if (!rst_n) begin
      v2_q    <= 1'b0;
      s2_re_q <= '0;
      s2_im_q <= '0;
      tag2_q  <= '0;
    end else if (en_c) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_re_q <= s_re_q;
        s2_im_q <= s_im_q;
        tag2_q  <= tag1_q;
      end
    end
  end

  cmul_conj_pipe #(
    .WIDTH  (WIDTH),
    .SCALE  (SCALE),
    .SAT_EN (SAT_EN)
  ) u_cmul (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld2_i   (en_c & v1_q),
    .ld3_i   (en_c & v2_q),
    .d_re_i  (d_re_q),
    .d_im_i  (d_im_q),
    .w_re_i  (w_re_q),
    .w_im_i  (w_im_q),
    .y_re_o  (Y_re),
    .y_im_o  (Y_im),
    .y_ovf_o (y_ovf)
  );

  always_comb begin
    n_xre  = sat_narrow(NARROW_W'(s2_re_q >>> SCALE), WIDTH, SAT_EN);
    n_xim  = sat_narrow(NARROW_W'(s2_im_q >>> SCALE), WIDTH, SAT_EN);
    x_re_d = n_xre.clamp ? (n_xre.neg ? Q_MIN : Q_MAX) : WIDTH'(s2_re_q >>> SCALE);
    x_im_d = n_xim.clamp ? (n_xim.neg ? Q_MIN : Q_MAX) : WIDTH'(s2_im_q >>> SCALE);
  end

  always_ff @(posedge clk or negedge rst_n) begin : s3_reg
    if (!rst_n) begin
      out_valid <= 1'b0;
      X_re      <= '0;
      X_im      <= '0;
      x_ovf_q   <= 1'b0;
      out_tag   <= '0;
    end else if (en_c) begin
      out_valid <= v2_q;
      if (v2_q) begin
        X_re    <= x_re_d;
        X_im    <= x_im_d;
        x_ovf_q <= n_xre.ovf | n_xim.ovf;
        out_tag <= tag2_q;
      end
    end
  end

  // Sticky flag: a set on the transfer cycle beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin : ovf_reg
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (xfer_c && (x_ovf_q || y_ovf)) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ibutterfly_dif_pipe.sv
// Bench for ibutterfly_dif_pipe: SCALE=0 and SCALE=1 instances share stimulus and are
// checked against an arithmetic model queue, plus directed literal expectations.
module tb_ibutterfly_dif_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, out_ready, ovf_clr;
  logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic [7:0]  in_tag;
  logic        in_ready [2];
  logic        out_valid [2];
  logic        ovf [2];
  logic [15:0] xr [2];
  logic [15:0] xi [2];
  logic [15:0] yr [2];
  logic [15:0] yi [2];
  logic [7:0]  otag [2];

  ibutterfly_dif_pipe #(.WIDTH(16), .SCALE(0), .TAG_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .in_tag(in_tag), .out_valid(out_valid[0]), .out_ready(out_ready),
    .X_re(xr[0]), .X_im(xi[0]), .Y_re(yr[0]), .Y_im(yi[0]), .out_tag(otag[0]),
    .ovf(ovf[0]), .ovf_clr(ovf_clr)
  );

  ibutterfly_dif_pipe #(.WIDTH(16), .SCALE(1), .TAG_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .in_tag(in_tag), .out_valid(out_valid[1]), .out_ready(out_ready),
    .X_re(xr[1]), .X_im(xi[1]), .Y_re(yr[1]), .Y_im(yi[1]), .out_tag(otag[1]),
    .ovf(ovf[1]), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [15:0] xr, xi, yr, yi;
    logic [7:0]  tag;
    bit          ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   ovf_exp [2];
  bit   hold_prev = 1'b0;
  logic [71:0] prev_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Narrow a mathematical result to signed 16 bits: {overflow, value}
  function automatic logic [16:0] nar(input longint v);
    logic [16:0] r;
    r = {(v < -32768) || (v > 32767), v[15:0]};
`ifdef IBFLY_SAT_EN
    if (r[16]) r[15:0] = (v < 0) ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  function automatic exp_t model(input int sc);
    exp_t        e;
    longint      ar, ai, br, bi, wr, wi, dr, di;
    logic [16:0] n0, n1, n2, n3;
    ar = longint'($signed(a_re)); ai = longint'($signed(a_im));
    br = longint'($signed(b_re)); bi = longint'($signed(b_im));
    wr = longint'($signed(w_re)); wi = longint'($signed(w_im));
    dr = ar - br;
    di = ai - bi;
    n0 = nar((ar + br) >>> sc);
    n1 = nar((ai + bi) >>> sc);
    n2 = nar((dr * wr + di * wi) >>> (15 + sc));
    n3 = nar((di * wr - dr * wi) >>> (15 + sc));
    e.xr = n0[15:0]; e.xi = n1[15:0]; e.yr = n2[15:0]; e.yi = n3[15:0];
    e.ov = n0[16] | n1[16] | n2[16] | n3[16];
    e.tag = in_tag;
    return e;
  endfunction

  // Compare process: sampled on the falling edge, between driver updates
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      ovf_exp[0] = 1'b0;
      ovf_exp[1] = 1'b0;
      hold_prev  = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        check($sformatf("ovf%0d", k), ovf[k], ovf_exp[k]);
        check($sformatf("in_ready%0d", k), in_ready[k], !out_valid[k] || out_ready);
        if (out_valid[k] && out_ready) begin
          if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("spurious_out%0d", k), 1, 0);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("X_re%0d tag%0h", k, e.tag), xr[k], e.xr);
            check($sformatf("X_im%0d tag%0h", k, e.tag), xi[k], e.xi);
            check($sformatf("Y_re%0d tag%0h", k, e.tag), yr[k], e.yr);
            check($sformatf("Y_im%0d tag%0h", k, e.tag), yi[k], e.yi);
            check($sformatf("tag%0d", k), otag[k], e.tag);
            if (e.ov) ovf_exp[k] = 1'b1;
            else if (ovf_clr) ovf_exp[k] = 1'b0;
          end
        end else if (ovf_clr) begin
          ovf_exp[k] = 1'b0;
        end
      end
      if (hold_prev) check("stall_hold", 32'(prev_out != {xr[0], xi[0], yr[0], yi[0], otag[0]}), 0);
      if (in_valid && in_ready[0]) begin
        q0.push_back(model(0));
        q1.push_back(model(1));
      end
      hold_prev = out_valid[0] && !out_ready;
      prev_out  = {xr[0], xi[0], yr[0], yi[0], otag[0]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] ar, ai, br, bi, wr, wi, input logic [7:0] t);
    a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi; in_tag = t;
  endtask

  task automatic send(input logic [15:0] ar, ai, br, bi, wr, wi, input logic [7:0] t);
    set_in(ar, ai, br, bi, wr, wi, t);
    in_valid = 1'b1;
    check("send_ready", in_ready[0], 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; counts edges until out_valid rises
  task automatic wait_out(input string name);
    int n = 1;
    while (!out_valid[0] && n < 10) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 3);
  endtask

  task automatic set_bp(input int idx);
    set_in(16'(16'h0100 * (idx + 1)), 16'(16'h0010 * idx), 16'h0040, 16'hFFF0,
           16'h4000, 16'hC000, 8'(idx));
  endtask

  initial begin
    int  idx;
    bit  acc;
    in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid[0], 0);
    check("rst_ovf", ovf[0], 0);
    check("rst_X_re", xr[0], 0);
    check("rst_Y_im", yi[1], 0);
    check("rst_tag", otag[0], 0);
    rst_n = 1'b1;
    tick();

    send(16'h2000, 16'h0, 16'h1000, 16'h0, 16'h7FFF, 16'h0, 8'h01);
    wait_out("basic");
    check("basic_X_re", xr[0], 16'h3000);
    check("basic_Y_re", yr[0], 16'h0FFF);
    check("basic_X_im", xi[0], 16'h0000);
    check("basic_Y_im", yi[0], 16'h0000);
    check("scale_X_re", xr[1], 16'h1800);
    check("scale_Y_re", yr[1], 16'h07FF);
    check("basic_ovf", ovf[0], 0);
    tick();

    send(16'h2000, 16'h0, 16'h1000, 16'h0, 16'h0000, 16'h7FFF, 8'h02);
    wait_out("conj");
    check("conj_Y_re", yr[0], 16'h0000);
    check("conj_Y_im", yi[0], 16'hF000);
    check("conj_X_re", xr[0], 16'h3000);
    tick();

    send(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 8'h03);
    wait_out("ovf");
`ifdef IBFLY_SAT_EN
    check("ovf_X_re", xr[0], 16'h7FFF);
`else
    check("ovf_X_re", xr[0], 16'hFFFE);
`endif
    tick();
    check("ovf_set", ovf[0], 1);
    send(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 8'h04);
    wait_out("ovf2");
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_set_wins", ovf[0], 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf[0], 0);
    tick();

    // Backpressure: six tagged sets against a stalled output
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 6);
      set_bp(idx);
      acc = in_valid && in_ready[0];
      tick();
      if (acc) idx++;
    end
    check("bp_accepted", idx, 3);
    check("bp_ready_low", in_ready[0], 0);
    check("bp_frozen_X_re", xr[0], 16'h0140);
    check("bp_frozen_tag", otag[0], 8'h00);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 6 || out_valid[0]); c++) begin
      in_valid = (idx < 6);
      set_bp(idx);
      acc = in_valid && in_ready[0];
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 6);
    check("bp_drained", q0.size(), 0);
    check("bp_out_idle", out_valid[0], 0);

    // Reset mid-flight: first entry overflows, three more remain in the pipe
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 8'h20);
      else set_in(16'h1000, 16'h0800, 16'h0400, 16'h0, 16'h7FFF, 16'h0, 8'(8'h20 + i));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("mid_ovf_before", ovf[0], 1);
    check("mid_valid_before", out_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid0", out_valid[0], 0);
    check("mid_rst_valid1", out_valid[1], 0);
    check("mid_rst_ovf", ovf[0], 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("post_rst_idle", out_valid[0], 0);
    end
    send(16'h0C00, 16'hF400, 16'h0400, 16'h0200, 16'h5A82, 16'hA57E, 8'h30);
    wait_out("post_rst");
    check("post_rst_tag", otag[0], 8'h30);
    repeat (3) tick();
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
